// File: rtl/wb_master_arbiter.sv
// Wishbone N-master to single-slave arbiter with fixed-priority or round-robin grant
// and a stall timeout that aborts the owning master's cycle with an error.
module wb_master_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_mosi,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_miso,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [SEL_WIDTH-1:0]              s_sel,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_mosi,
  input  logic                              s_ack,
  input  logic                              s_err,
  input  logic [DATA_WIDTH-1:0]             s_dat_miso,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              timeout
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [IdxW-1:0]        win_idx;
  logic                   busy;
  logic                   abort;

  logic [SEL_WIDTH-1:0]   sel_arr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];

  assign req   = m_cyc & m_stb;
  assign busy  = !rst && (state_q == StBusy);
  assign abort = !rst && (state_q == StAbort);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    assign sel_arr[i] = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
    assign adr_arr[i] = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[i] = m_dat_mosi[i*DATA_WIDTH +: DATA_WIDTH];

    // Slave responses reach only the owner, and only while the bus is really owned.
    assign m_ack[i] = busy && grant_q[i] && s_ack;
    assign m_err[i] = grant_q[i] && ((busy && s_err) || abort);
    assign m_dat_miso[i*DATA_WIDTH +: DATA_WIDTH] = (busy && grant_q[i]) ? s_dat_miso : '0;
  end

  // Winner selection; loops run downward so the highest-priority candidate is written last.
  always_comb begin
    win_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
        if (req[IdxW'(i)]) win_idx = IdxW'(i);
      end
    end else begin
      for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
        if (req[IdxW'((int'(last_q) + k) % int'(NUM_MASTERS))]) begin
          win_idx = IdxW'((int'(last_q) + k) % int'(NUM_MASTERS));
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (|req) begin
          state_d   = StBusy;
          grant_d   = '0;
          grant_d[win_idx] = 1'b1;
          gnt_idx_d = win_idx;
          last_d    = win_idx;
        end
      end
      StBusy: begin
        if (!m_cyc[gnt_idx_q]) begin
          state_d = StIdle;
          grant_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && m_stb[gnt_idx_q] && !s_ack && !s_err &&
                     (cnt_q == CntLast)) begin
          // This stalled cycle brings the count to the limit.
          state_d = StAbort;
        end
        if (s_ack || s_err) begin
          cnt_d = '0;
        end else if (m_stb[gnt_idx_q] && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAbort: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gnt_idx_q <= '0;
      last_q    <= LastRst;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_sel      = '0;
    s_adr      = '0;
    s_dat_mosi = '0;
    if (busy) begin
      s_cyc      = m_cyc[gnt_idx_q];
      s_stb      = m_stb[gnt_idx_q];
      s_we       = m_we[gnt_idx_q];
      s_sel      = sel_arr[gnt_idx_q];
      s_adr      = adr_arr[gnt_idx_q];
      s_dat_mosi = dat_arr[gnt_idx_q];
    end
  end

  assign grant   = rst ? '0 : grant_q;
  assign timeout = abort;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench: instance a = defaults, c = same bus with a 4-cycle timeout,
// b = three masters in round-robin mode.
module tb_wb_master_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for instances a and c
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [63:0] m_adr, m_dat_mosi;
  logic        s_ack, s_err;
  logic [31:0] s_dat_miso;

  logic [1:0]  a_m_ack, a_m_err, a_grant;
  logic [63:0] a_m_dat_miso;
  logic        a_s_cyc, a_s_stb, a_s_we, a_timeout;
  logic [3:0]  a_s_sel;
  logic [31:0] a_s_adr, a_s_dat_mosi;

  logic [1:0]  c_m_ack, c_m_err, c_grant;
  logic [63:0] c_m_dat_miso;
  logic        c_s_cyc, c_s_stb, c_s_we, c_timeout;
  logic [3:0]  c_s_sel;
  logic [31:0] c_s_adr, c_s_dat_mosi;

  logic [2:0]  b_m_cyc, b_m_stb, b_m_we;
  logic [11:0] b_m_sel;
  logic [95:0] b_m_adr, b_m_dat_mosi;
  logic        b_s_ack, b_s_err;
  logic [31:0] b_s_dat_miso;
  logic [2:0]  b_m_ack, b_m_err, b_grant;
  logic [95:0] b_m_dat_miso;
  logic        b_s_cyc, b_s_stb, b_s_we, b_timeout;
  logic [3:0]  b_s_sel;
  logic [31:0] b_s_adr, b_s_dat_mosi;

  int vectors = 0;
  int miscompares = 0;

  wb_master_arbiter u_a (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_mosi(m_dat_mosi), .m_ack(a_m_ack), .m_err(a_m_err),
    .m_dat_miso(a_m_dat_miso), .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we),
    .s_sel(a_s_sel), .s_adr(a_s_adr), .s_dat_mosi(a_s_dat_mosi), .s_ack(s_ack),
    .s_err(s_err), .s_dat_miso(s_dat_miso), .grant(a_grant), .timeout(a_timeout)
  );

  wb_master_arbiter #(.TIMEOUT_CYCLES(4)) u_c (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_mosi(m_dat_mosi), .m_ack(c_m_ack), .m_err(c_m_err),
    .m_dat_miso(c_m_dat_miso), .s_cyc(c_s_cyc), .s_stb(c_s_stb), .s_we(c_s_we),
    .s_sel(c_s_sel), .s_adr(c_s_adr), .s_dat_mosi(c_s_dat_mosi), .s_ack(s_ack),
    .s_err(s_err), .s_dat_miso(s_dat_miso), .grant(c_grant), .timeout(c_timeout)
  );

  wb_master_arbiter #(.NUM_MASTERS(3), .ARB_MODE(1)) u_b (
    .clk(clk), .rst(rst), .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_sel(b_m_sel),
    .m_adr(b_m_adr), .m_dat_mosi(b_m_dat_mosi), .m_ack(b_m_ack), .m_err(b_m_err),
    .m_dat_miso(b_m_dat_miso), .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we),
    .s_sel(b_s_sel), .s_adr(b_s_adr), .s_dat_mosi(b_s_dat_mosi), .s_ack(b_s_ack),
    .s_err(b_s_err), .s_dat_miso(b_s_dat_miso), .grant(b_grant), .timeout(b_timeout)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks follow 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_mosi = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_miso = '0;
    b_m_cyc = '0; b_m_stb = '0; b_m_we = '0; b_m_sel = '0; b_m_adr = '0; b_m_dat_mosi = '0;
    b_s_ack = 1'b0; b_s_err = 1'b0; b_s_dat_miso = '0;

    step(); #1;
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_s_cyc", a_s_cyc, 1'b0);
    chk("rst_timeout", a_timeout, 1'b0);
    chk("rst_b_grant", b_grant, 3'b000);

    // Both masters request together
    step();
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b01; m_sel = {4'h3, 4'hF};
    m_adr = {32'h0000_2000, 32'h0000_1000};
    m_dat_mosi = {32'h2222_2222, 32'h1111_1111};
    #1;
    chk("req_cycle_grant", a_grant, 2'b00);
    chk("req_cycle_s_cyc", a_s_cyc, 1'b0);

    step(); #1;
    chk("m0_grant", a_grant, 2'b01);
    chk("m0_s_cyc", a_s_cyc, 1'b1);
    chk("m0_s_adr", a_s_adr, 32'h0000_1000);
    chk("m0_s_we", a_s_we, 1'b1);
    chk("m0_s_sel", a_s_sel, 4'hF);
    chk("m0_s_dat_mosi", a_s_dat_mosi, 32'h1111_1111);
    s_ack = 1'b1; s_dat_miso = 32'hDEAD_BEEF;
    #1;
    chk("m0_ack", a_m_ack, 2'b01);
    chk("m0_err", a_m_err, 2'b00);
    chk("m0_dat_miso", a_m_dat_miso, {32'h0, 32'hDEAD_BEEF});

    step();
    s_ack = 1'b0;
    #1;
    chk("m0_hold_grant", a_grant, 2'b01);
    chk("m0_hold_ack", a_m_ack, 2'b00);

    step();
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    chk("m0_drop_grant", a_grant, 2'b01);
    chk("m0_drop_s_cyc", a_s_cyc, 1'b0);

    step(); #1;
    chk("gap_grant", a_grant, 2'b00);
    chk("gap_s_cyc", a_s_cyc, 1'b0);

    step(); #1;
    chk("m1_grant", a_grant, 2'b10);
    chk("m1_s_adr", a_s_adr, 32'h0000_2000);
    chk("m1_s_we", a_s_we, 1'b0);
    chk("m1_s_sel", a_s_sel, 4'h3);
    // ack+err together while the owner drops cyc
    s_ack = 1'b1; s_err = 1'b1; s_dat_miso = 32'hCAFE_F00D;
    m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    chk("m1_ack", a_m_ack, 2'b10);
    chk("m1_err", a_m_err, 2'b10);
    chk("m1_dat_miso", a_m_dat_miso, {32'hCAFE_F00D, 32'h0});
    chk("m1_s_cyc_low", a_s_cyc, 1'b0);

    step(); #1;
    chk("idle_ack_ignored", a_m_ack, 2'b00);
    chk("idle_err_ignored", a_m_err, 2'b00);
    chk("idle_dat_zero", a_m_dat_miso, 64'h0);
    chk("idle_grant", a_grant, 2'b00);
    chk("c_idle_grant", c_grant, 2'b00);

    // Timeout on instance c: master 0 stalls forever
    s_ack = 1'b0; s_err = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01;
    step(); #1;
    chk("to_grant", c_grant, 2'b01);
    chk("to_s_cyc", c_s_cyc, 1'b1);
    step();
    step();
    step(); #1;
    chk("to_pre_timeout", c_timeout, 1'b0);
    chk("to_pre_err", c_m_err, 2'b00);
    chk("to_pre_grant", c_grant, 2'b01);

    step();
    s_ack = 1'b1;
    #1;
    chk("to_timeout", c_timeout, 1'b1);
    chk("to_err", c_m_err, 2'b01);
    chk("to_abort_grant", c_grant, 2'b01);
    chk("to_abort_s_cyc", c_s_cyc, 1'b0);
    chk("to_abort_ack_ignored", c_m_ack, 2'b00);

    step();
    s_ack = 1'b0;
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    chk("to_after_grant", c_grant, 2'b00);
    chk("to_after_timeout", c_timeout, 1'b0);

    // Reset mid-transaction on instance a
    step();
    step(); #1;
    chk("pre_rst_grant", a_grant, 2'b10);
    rst = 1'b1; s_ack = 1'b1;
    #1;
    chk("rst_held_grant", a_grant, 2'b00);
    chk("rst_held_s_cyc", a_s_cyc, 1'b0);
    chk("rst_held_ack", a_m_ack, 2'b00);

    step();
    rst = 1'b0; s_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    chk("post_rst_grant", a_grant, 2'b00);
    chk("post_rst_s_cyc", a_s_cyc, 1'b0);

    step(); #1;
    chk("post_rst_first", a_grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00;

    // Round-robin with three masters and single-beat cycles
    step();
    b_m_cyc = 3'b111; b_m_stb = 3'b111;
    #1;
    chk("rr_idle", b_grant, 3'b000);

    step(); #1;
    chk("rr_g0", b_grant, 3'b001);
    b_s_ack = 1'b1; b_m_cyc[0] = 1'b0; b_m_stb[0] = 1'b0;
    #1;
    chk("rr_ack0", b_m_ack, 3'b001);

    step();
    b_s_ack = 1'b0; b_m_cyc[0] = 1'b1; b_m_stb[0] = 1'b1;
    #1;
    chk("rr_gap", b_grant, 3'b000);

    step(); #1;
    chk("rr_g1", b_grant, 3'b010);
    b_s_ack = 1'b1; b_m_cyc[1] = 1'b0; b_m_stb[1] = 1'b0;
    step();
    b_s_ack = 1'b0; b_m_cyc[1] = 1'b1; b_m_stb[1] = 1'b1;

    step(); #1;
    chk("rr_g2", b_grant, 3'b100);
    b_s_ack = 1'b1; b_m_cyc[2] = 1'b0; b_m_stb[2] = 1'b0;
    step();
    b_s_ack = 1'b0; b_m_cyc[2] = 1'b1; b_m_stb[2] = 1'b1;

    step(); #1;
    chk("rr_g0_again", b_grant, 3'b001);
    b_s_ack = 1'b1; b_m_cyc[0] = 1'b0; b_m_stb[0] = 1'b0;
    step();
    b_s_ack = 1'b0; b_m_cyc[0] = 1'b1; b_m_stb[0] = 1'b1;

    step(); #1;
    chk("rr_g1_again", b_grant, 3'b010);
    rst = 1'b1;

    step();
    rst = 1'b0;
    #1;
    chk("rr_post_rst_grant", b_grant, 3'b000);
    chk("rr_post_rst_s_cyc", b_s_cyc, 1'b0);

    step(); #1;
    chk("rr_post_rst_first", b_grant, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
